// File: rtl/btb_ctrl.sv
// Lookup/update controller for a 32 x 26-bit BTB SRAM: tag compare, valid bits, update queue + RMW FSM.
// Optional hit/miss statistics counters are enabled by defining BTB_STATS_EN.
module btb_ctrl #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lk_valid,
    input  logic [14:0] lk_pc,
    output logic        lk_rvalid,
    output logic        lk_hit,
    output logic [14:0] lk_target,
    output logic        lk_taken,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [14:0] upd_pc,
    input  logic [14:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush,
    output logic        mem_cs,
    output logic        mem_web,
    output logic [4:0]  mem_wa,
    output logic [25:0] mem_wd,
    output logic [4:0]  mem_ra,
    input  logic [25:0] mem_rd
`ifdef BTB_STATS_EN
    ,
    output logic [15:0] stat_hit,
    output logic [15:0] stat_miss
`endif
);

    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [QW:0] Q_FULL = (QW + 1)'(QDEPTH);

    localparam logic [0:0] U_IDLE = 1'b0;
    localparam logic [0:0] U_CMP  = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic [31:0] valid;

    // Update queue: {pc, target, taken}
    logic [30:0]   q_mem [QDEPTH];
    logic [QW-1:0] q_wr_ptr;
    logic [QW-1:0] q_rd_ptr;
    logic [QW:0]   q_count;
    logic          q_full;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;

    logic [14:0] head_pc;
    logic [14:0] head_tgt;
    logic        head_tk;
    logic [4:0]  head_idx;
    logic [9:0]  head_tag;

    logic        in_cmp;
    logic        cmp_hit;
    logic        cmp_wr;
    logic        cmp_clr;
    logic [25:0] cmp_wd;
    logic        do_write;
    logic        lk_rd;
    logic        fsm_rd;

    logic        lk_pend;
    logic [4:0]  lk_idx;
    logic [9:0]  lk_tag;
    logic        fwd;
    logic [25:0] fwd_data;
    logic [25:0] rd_entry;
    logic        hit_c;

    assign q_full    = (q_count == Q_FULL);
    assign q_empty   = (q_count == '0);
    assign upd_ready = !q_full && !flush;
    assign q_push    = upd_valid && upd_ready;
    assign in_cmp    = (state == U_CMP);
    assign q_pop     = in_cmp && !flush;

    assign head_pc  = q_mem[q_rd_ptr][30:16];
    assign head_tgt = q_mem[q_rd_ptr][15:1];
    assign head_tk  = q_mem[q_rd_ptr][0];
    assign head_idx = head_pc[4:0];
    assign head_tag = head_pc[14:5];

    // In U_CMP, mem_rd holds the head entry read during U_IDLE; only this FSM writes the SRAM,
    // so the entry cannot have changed in between.
    assign cmp_hit = valid[head_idx] && (mem_rd[25:16] == head_tag);
    assign cmp_wr  = head_tk || (cmp_hit && mem_rd[0]);
    assign cmp_clr = !head_tk && cmp_hit && !mem_rd[0];
    assign cmp_wd  = head_tk ? {head_tag, head_tgt, 1'b1} : {head_tag, mem_rd[15:1], 1'b0};

    assign do_write = rst_n && in_cmp && cmp_wr && !flush;
    assign lk_rd    = rst_n && lk_valid;
    assign fsm_rd   = rst_n && (state == U_IDLE) && !q_empty && !lk_valid && !flush;

    always_comb begin
        mem_ra = 5'd0;
        if (lk_rd) begin
            mem_ra = lk_pc[4:0];
        end else if (fsm_rd) begin
            mem_ra = head_idx;
        end
    end

    assign mem_cs  = lk_rd || fsm_rd || do_write;
    assign mem_web = !do_write;
    assign mem_wa  = do_write ? head_idx : 5'd0;
    assign mem_wd  = do_write ? cmp_wd : 26'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            U_IDLE:  state_nxt = fsm_rd ? U_CMP : U_IDLE;
            U_CMP:   state_nxt = U_IDLE;
            default: state_nxt = U_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= U_IDLE;
        end else if (flush) begin
            state <= U_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (do_write) begin
            valid[head_idx] <= 1'b1;
        end else if (in_cmp && cmp_clr) begin
            valid[head_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_mem[q_wr_ptr] <= {upd_pc, upd_target, upd_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            q_count  <= '0;
        end else begin
            if (q_push) begin
                q_wr_ptr <= q_wr_ptr + 1'b1;
            end
            if (q_pop) begin
                q_rd_ptr <= q_rd_ptr + 1'b1;
            end
            case ({q_push, q_pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // A lookup colliding with this cycle's write reads stale SRAM data, so the write is captured for bypass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lk_pend  <= 1'b0;
            lk_idx   <= 5'd0;
            lk_tag   <= 10'd0;
            fwd      <= 1'b0;
            fwd_data <= 26'd0;
        end else begin
            lk_pend  <= lk_rd;
            lk_idx   <= lk_pc[4:0];
            lk_tag   <= lk_pc[14:5];
            fwd      <= lk_rd && do_write && (head_idx == lk_pc[4:0]);
            fwd_data <= cmp_wd;
        end
    end

    assign rd_entry  = fwd ? fwd_data : mem_rd;
    assign hit_c     = lk_pend && valid[lk_idx] && (rd_entry[25:16] == lk_tag);
    assign lk_rvalid = lk_pend;
    assign lk_hit    = hit_c;
    assign lk_target = hit_c ? rd_entry[15:1] : 15'd0;
    assign lk_taken  = hit_c && rd_entry[0];

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hit  <= 16'd0;
            stat_miss <= 16'd0;
        end else if (lk_pend) begin
            if (hit_c) begin
                if (stat_hit != 16'hFFFF) begin
                    stat_hit <= stat_hit + 16'd1;
                end
            end else begin
                if (stat_miss != 16'hFFFF) begin
                    stat_miss <= stat_miss + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl with an SRAM model, a lookup-result scoreboard and a write-order scoreboard.
module tb_btb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lk_valid;
    logic [14:0] lk_pc;
    logic        lk_rvalid;
    logic        lk_hit;
    logic [14:0] lk_target;
    logic        lk_taken;
    logic        upd_valid;
    logic        upd_ready;
    logic [14:0] upd_pc;
    logic [14:0] upd_target;
    logic        upd_taken;
    logic        flush;
    logic        mem_cs;
    logic        mem_web;
    logic [4:0]  mem_wa;
    logic [25:0] mem_wd;
    logic [4:0]  mem_ra;
    logic [25:0] mem_rd;
`ifdef BTB_STATS_EN
    logic [15:0] stat_hit;
    logic [15:0] stat_miss;
`endif

    int checks = 0;
    int errors = 0;

    // Lookup results {hit, target, taken}; writes {addr, data}
    logic [16:0] exp_q[$];
    logic [30:0] wr_q[$];

    logic [25:0] mem_arr [32];

    btb_ctrl #(.QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_rvalid(lk_rvalid), .lk_hit(lk_hit),
        .lk_target(lk_target), .lk_taken(lk_taken),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush),
        .mem_cs(mem_cs), .mem_web(mem_web), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_ra(mem_ra), .mem_rd(mem_rd)
`ifdef BTB_STATS_EN
        , .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // SRAM model: registered read, read-before-write on address collision
    always @(posedge clk) begin
        if (mem_cs) begin
            if (!mem_web) mem_arr[mem_wa] <= mem_wd;
            mem_rd <= mem_arr[mem_ra];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] le(input logic h, input logic [14:0] t, input logic k);
        return {h, t, k};
    endfunction

    function automatic logic [30:0] we(input logic [14:0] pc, input logic [14:0] t, input logic k);
        return {pc[4:0], pc[14:5], t, k};
    endfunction

    always @(negedge clk) begin
        if (rst_n && lk_rvalid) begin
            if (exp_q.size() == 0) check("lk_unexpected", 32'(lk_rvalid), 32'd0);
            else check("lk_result", 32'({lk_hit, lk_target, lk_taken}), 32'(exp_q.pop_front()));
        end
        if (rst_n && mem_cs && !mem_web) begin
            if (wr_q.size() == 0) check("wr_unexpected", 32'({mem_wa, mem_wd}), 32'd0);
            else check("wr_order", 32'({mem_wa, mem_wd}), 32'(wr_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_lookup(input logic [14:0] pc, input logic [16:0] e);
        lk_valid = 1'b1;
        lk_pc    = pc;
        exp_q.push_back(e);
        tick();
        lk_valid = 1'b0;
        lk_pc    = 15'($urandom_range(0, 32767));
    endtask

    // Returns one cycle after the accepting edge.
    task automatic do_update(input logic [14:0] pc, input logic [14:0] t, input logic k,
                             input logic w, input logic [30:0] wd);
        int n = 0;
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = t;
        upd_taken  = k;
        #1;
        while (!upd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("upd_timeout", 32'(upd_ready), 32'd1);
        if (w) wr_q.push_back(wd);
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int web_low;
        logic [14:0] spc [3];
        logic [14:0] stg [3];
        spc[0] = 15'h0045; stg[0] = 15'h0AAA;
        spc[1] = 15'h0046; stg[1] = 15'h0BBB;
        spc[2] = 15'h0047; stg[2] = 15'h0CCC;
        for (int i = 0; i < 32; i++) mem_arr[i] = 26'($urandom);
        rst_n = 1'b0; lk_valid = 1'b0; lk_pc = 15'd0; upd_valid = 1'b0;
        upd_pc = 15'd0; upd_target = 15'd0; upd_taken = 1'b0; flush = 1'b0;
        idle(3);
        check("rst_rvalid", 32'(lk_rvalid), 32'd0);
        check("rst_target", 32'(lk_target), 32'd0);
        check("rst_cs", 32'(mem_cs), 32'd0);
        check("rst_web", 32'(mem_web), 32'd1);
        check("rst_ra_wa", 32'({mem_ra, mem_wa}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(upd_ready), 32'd1);

        do_lookup(15'h0123, le(1'b0, 15'h0, 1'b0));
        idle(1);

        do_update(15'h0123, 15'h4000, 1'b1, 1'b1, we(15'h0123, 15'h4000, 1'b1));
        idle(3);
        do_lookup(15'h0123, le(1'b1, 15'h4000, 1'b1));
        do_lookup(15'h0023, le(1'b0, 15'h0, 1'b0));

        do_update(15'h0123, 15'h7777, 1'b0, 1'b1, we(15'h0123, 15'h4000, 1'b0));
        idle(3);
        do_lookup(15'h0123, le(1'b1, 15'h4000, 1'b0));
        do_update(15'h0123, 15'h7777, 1'b0, 1'b0, 31'd0);
        idle(3);
        do_lookup(15'h0123, le(1'b0, 15'h0, 1'b0));
        idle(2);

        // Lookup stream starves the update FSM; queue fills at two entries.
        acc = 0;
        web_low = 0;
        for (int i = 0; i < 10; i++) begin
            lk_valid   = 1'b1;
            lk_pc      = 15'h0200 + 15'(i);
            upd_valid  = 1'b1;
            upd_pc     = spc[acc];
            upd_target = stg[acc];
            upd_taken  = 1'b1;
            exp_q.push_back(le(1'b0, 15'h0, 1'b0));
            #1;
            if (!mem_web) web_low++;
            if (upd_ready) begin
                wr_q.push_back(we(spc[acc], stg[acc], 1'b1));
                acc++;
            end
            tick();
        end
        check("stream_accepted", 32'(acc), 32'd2);
        check("stream_ready_low", 32'(upd_ready), 32'd0);
        check("stream_no_write", 32'(web_low), 32'd0);
        lk_valid = 1'b0;
        do_update(spc[2], stg[2], 1'b1, 1'b1, we(spc[2], stg[2], 1'b1));
        idle(8);
        check("drain_done", 32'(wr_q.size()), 32'd0);
        do_lookup(15'h0045, le(1'b1, 15'h0AAA, 1'b1));
        do_lookup(15'h0046, le(1'b1, 15'h0BBB, 1'b1));
        do_lookup(15'h0047, le(1'b1, 15'h0CCC, 1'b1));
        idle(2);

        // Lookup lands in the same cycle as the U_CMP write to index 3.
        do_update(15'h0063, 15'h1111, 1'b1, 1'b1, we(15'h0063, 15'h1111, 1'b1));
        tick();
        do_lookup(15'h0063, le(1'b1, 15'h1111, 1'b1));
        idle(2);
        do_lookup(15'h0063, le(1'b1, 15'h1111, 1'b1));
        idle(2);

        // Flush while an update sits in the queue (FSM about to read).
        do_update(15'h0064, 15'h2222, 1'b1, 1'b0, 31'd0);
        flush = 1'b1;
        #1;
        check("flush_ready_low", 32'(upd_ready), 32'd0);
        tick();
        flush = 1'b0;
        do_lookup(15'h0063, le(1'b0, 15'h0, 1'b0));
        do_lookup(15'h0064, le(1'b0, 15'h0, 1'b0));
        idle(4);

        // Flush during U_CMP suppresses the write; concurrent lookup misses.
        do_update(15'h0065, 15'h3333, 1'b1, 1'b0, 31'd0);
        tick();
        flush = 1'b1;
        #1;
        check("flush_cmp_web", 32'(mem_web), 32'd1);
        do_lookup(15'h0065, le(1'b0, 15'h0, 1'b0));
        flush = 1'b0;
        idle(4);
        do_lookup(15'h0065, le(1'b0, 15'h0, 1'b0));
        idle(3);

        check("lk_queue_empty", 32'(exp_q.size()), 32'd0);
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
- Lookup/update controller for the 32-entry x 26-bit dual-port branch target buffer memory (registered read, 1-cycle latency, shared chip select).
- Drives the memory read/write address, write data, write enable and chip select; tag-compares read data; owns the entry valid bits in flops, because the SRAM has no reset.
- Sits between the fetch stage (lookups) and the branch-resolve stage (updates).

Parameters:
QDEPTH, 2, depth of the update request queue (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lk_valid  in  1  lookup request this cycle
lk_pc  in  15  lookup PC
lk_rvalid  out  1  lookup result valid
lk_hit  out  1  BTB hit
lk_target  out  15  predicted target
lk_taken  out  1  taken hint
upd_valid  in  1  update request
upd_ready  out  1  update accepted when valid&ready
upd_pc  in  15  resolved branch PC
upd_target  in  15  resolved target
upd_taken  in  1  resolved direction
flush  in  1  invalidate all entries, drop queue
mem_cs  out  1  memory chip select
mem_web  out  1  memory write enable, active low
mem_wa  out  5  write address
mem_wd  out  26  write data
mem_ra  out  5  read address
mem_rd  in  26  read data, valid the cycle after mem_ra

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset clears: valid bits, queue, FSM state (U_IDLE), lk_rvalid, lk_hit, lk_taken, lk_target=0, mem_web=1, mem_cs=0, mem_wa/mem_wd/mem_ra=0.
- Entry format: [25:16] tag = pc[14:5]; [15:1] target; [0] taken hint. Index = pc[4:0].
- Lookup:
  - Cycle N with lk_valid=1: mem_ra = lk_pc[4:0]; idx/tag are registered.
  - Cycle N+1: lk_rvalid=1; lk_hit = valid[idx] & (tag field == registered tag); lk_target/lk_taken come from the entry.
  - On a miss: lk_target=0, lk_taken=0.
  - Lookup has read-port priority over updates, every cycle.
- Forwarding: if a write in cycle N has mem_wa == mem_ra of a lookup in cycle N, the N+1 result uses the registered write data and post-write valid, not mem_rd.
- Queue:
  - upd_ready = !full & !flush.
  - Accepted updates are stored in FIFO order.
  - Accept and pop in the same cycle when full: not allowed (ready is already low).
- Update FSM:
  - U_IDLE: if queue non-empty & lk_valid=0 -> mem_ra = head index, go to U_CMP.
  - U_CMP (mem_rd is head's entry): hit = valid & tag match. Decide:
    - taken=1: write {tag, target, 1}, set valid.
    - taken=0, hit, hint=1: write {tag, old target, 0}.
    - taken=0, hit, hint=0: clear valid, no write.
    - taken=0, miss: no action.
  - After the decision: pop head, go to U_IDLE.
  - The write is issued combinationally in U_CMP: mem_web=0, mem_wa, mem_wd.
- Valid bits update at the clock edge ending the write cycle.
- mem_cs = read or write active this cycle; otherwise 0.
- Flush (cycle N):
  - Clears all valid bits and empties the queue at the edge.
  - FSM -> U_IDLE; any U_CMP write in cycle N is suppressed (mem_web=1).
  - A lookup whose result appears in N+1 reports a miss.
- Reset mid-operation: same as flush plus output reset values; an in-flight lookup produces no lk_rvalid.

Optional Feature:
BTB_STATS_EN
- Defined: adds outputs stat_hit[15:0] and stat_miss[15:0], counting lk_rvalid results.
  - Counters saturate at 0xFFFF.
  - Cleared by reset only, not by flush.
- Undefined: the ports and counters do not exist.

Test Plan:
- Reset, lookup lk_pc=0x0123 -> next cycle lk_rvalid=1, lk_hit=0, lk_target=0.
- Update pc=0x0123, target=0x4000, taken=1; idle 3 cycles; lookup 0x0123 -> hit=1, target=0x4000, taken=1. Lookup 0x0023 (same index, other tag) -> hit=0.
- Two taken=0 updates to 0x0123:
  - After the first: hit=1, taken=0, target=0x4000.
  - After the second: hit=0.
- lk_valid=1 for 10 cycles with 3 updates offered -> upd_ready drops after 2 accepted. No mem_web=0 during the stream. Updates drain in order afterwards.
- Lookup index 0x03 issued in the same cycle as a U_CMP write to index 0x03 (target 0x1111) -> result forwarded: hit=1, target=0x1111.
- After the entry is valid, assert flush with a queued update -> next lookup misses, queue empty, no write issued.
